// File: rtl/dht11_request_ctrl_if.sv
// Command/response and capture-stage signals shared by the DHT11 request controller.
// The controller takes the slave modport. The host or testbench takes the master modport.
interface dht11_request_ctrl_if;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic        cmd_ready;
    logic        dht_start;
    logic [39:0] dht_data;
    logic        dht_error;
    logic        dht_done;
    logic        tx_valid;
    logic [7:0]  tx_byte;
    logic        tx_ready;
    logic        busy;

    modport slave (
        input  cmd_valid, cmd_code, dht_data, dht_error, dht_done, tx_ready,
        output cmd_ready, dht_start, tx_valid, tx_byte, busy
    );

    modport master (
        output cmd_valid, cmd_code, dht_data, dht_error, dht_done, tx_ready,
        input  cmd_ready, dht_start, tx_valid, tx_byte, busy
    );
endinterface

// File: rtl/dht11_request_ctrl.sv
// DHT11 request front end: one read command in, sensor trigger, done/timeout wait, two-byte reply out.
// States: IDLE await cmd | TRIG hold dht_start | WAIT await done or timeout | SEND0/SEND1 emit resp0/resp1
module dht11_request_ctrl #(
    parameter int TIMEOUT_CYCLES = 1_200_000,
    parameter int START_HOLD     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dht11_request_ctrl_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(START_HOLD - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] COUNT_ONE    = CW'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_TRIG  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_SEND0 = 3'd3;
    localparam logic [2:0] S_SEND1 = 3'd4;

    localparam logic [7:0] CMD_STATUS = 8'h00;
    localparam logic [7:0] CMD_HUM    = 8'h01;
    localparam logic [7:0] CMD_TEMP   = 8'h02;

    localparam logic [7:0] RESP_INVALID = 8'hFF;
    localparam logic [7:0] RESP_CSUM    = 8'h1E;
    localparam logic [7:0] RESP_TIMEOUT = 8'h1D;
    localparam logic [7:0] RESP_STATUS  = 8'h1F;
    localparam logic [7:0] RESP_HUM     = 8'h3F;
    localparam logic [7:0] RESP_TEMP    = 8'h4F;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [7:0]    cmd;
    logic [7:0]    cmd_nxt;
    logic [7:0]    resp0;
    logic [7:0]    resp0_nxt;
    logic [7:0]    resp1;
    logic [7:0]    resp1_nxt;

    logic          cmd_accept;
    logic          cmd_known;
    logic          tx_accept;

    assign cmd_accept = (state == S_IDLE) && bus.cmd_valid;
    assign tx_accept  = ((state == S_SEND0) || (state == S_SEND1)) && bus.tx_ready;

    always_comb begin
        cmd_known = 1'b0;
        case (bus.cmd_code)
            CMD_STATUS, CMD_HUM, CMD_TEMP: cmd_known = 1'b1;
            default:                       cmd_known = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        cmd_nxt   = cmd;
        resp0_nxt = resp0;
        resp1_nxt = resp1;

        case (state)
            S_IDLE: begin
                if (cmd_accept) begin
                    cmd_nxt = bus.cmd_code;
                    if (cmd_known) begin
                        count_nxt = '0;
                        state_nxt = S_TRIG;
                    end else begin
                        resp0_nxt = RESP_INVALID;
                        resp1_nxt = RESP_INVALID;
                        state_nxt = S_SEND0;
                    end
                end
            end

            // The timeout counter starts on the first TRIG cycle so the
            // budget covers the trigger pulse and the wait.
            S_TRIG: begin
                count_nxt = count + COUNT_ONE;
                if (count == HOLD_LAST) begin
                    state_nxt = S_WAIT;
                end
            end

            S_WAIT: begin
                count_nxt = count + COUNT_ONE;
                if (bus.dht_done) begin
                    state_nxt = S_SEND0;
                    if (bus.dht_error) begin
                        resp0_nxt = RESP_CSUM;
                        resp1_nxt = cmd;
                    end else begin
                        case (cmd)
                            CMD_STATUS: begin
                                resp0_nxt = RESP_STATUS;
                                resp1_nxt = 8'h00;
                            end
                            CMD_HUM: begin
                                resp0_nxt = RESP_HUM;
                                resp1_nxt = bus.dht_data[39:32];
                            end
                            default: begin
                                resp0_nxt = RESP_TEMP;
                                resp1_nxt = bus.dht_data[23:16];
                            end
                        endcase
                    end
                end else if (count == TIMEOUT_LAST) begin
                    resp0_nxt = RESP_TIMEOUT;
                    resp1_nxt = cmd;
                    state_nxt = S_SEND0;
                end
            end

            S_SEND0: begin
                if (tx_accept) begin
                    state_nxt = S_SEND1;
                end
            end

            S_SEND1: begin
                if (tx_accept) begin
                    state_nxt = S_IDLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            count <= '0;
            cmd   <= 8'h00;
            resp0 <= 8'h00;
            resp1 <= 8'h00;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            cmd   <= cmd_nxt;
            resp0 <= resp0_nxt;
            resp1 <= resp1_nxt;
        end
    end

    assign bus.cmd_ready = (state == S_IDLE);
    assign bus.dht_start = (state == S_TRIG);
    assign bus.tx_valid  = (state == S_SEND0) || (state == S_SEND1);
    assign bus.busy      = (state != S_IDLE);
    assign bus.tx_byte   = (state == S_SEND0) ? resp0 :
                           (state == S_SEND1) ? resp1 : 8'h00;
endmodule

// File: tb/tb_dht11_request_ctrl.sv
// Directed bench for dht11_request_ctrl with a short timeout so the timeout path is reachable.
module tb_dht11_request_ctrl;
    localparam int TO   = 100;
    localparam int HOLD = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    dht11_request_ctrl_if bus ();

    dht11_request_ctrl #(
        .TIMEOUT_CYCLES (TO),
        .START_HOLD     (HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset cmd_ready: got %b want 1", bus.cmd_ready); end
        checks++;
        if (bus.dht_start !== 1'b0) begin failures++; $display("FAIL reset dht_start: got %b want 0", bus.dht_start); end
        checks++;
        if (bus.tx_valid !== 1'b0) begin failures++; $display("FAIL reset tx_valid: got %b want 0", bus.tx_valid); end
        checks++;
        if (bus.tx_byte !== 8'h00) begin failures++; $display("FAIL reset tx_byte: got %h want 00", bus.tx_byte); end
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    endtask

    // Each entry: command, error flag, expected resp0/resp1, done pulsed 50 cycles after the trigger.
    task automatic test_reads;
        logic [7:0] t_code [0:3];
        logic       t_err  [0:3];
        logic [7:0] t_r0   [0:3];
        logic [7:0] t_r1   [0:3];
        int         bad;
        t_code[0] = 8'h01; t_err[0] = 1'b0; t_r0[0] = 8'h3F; t_r1[0] = 8'h3C;
        t_code[1] = 8'h02; t_err[1] = 1'b0; t_r0[1] = 8'h4F; t_r1[1] = 8'h19;
        t_code[2] = 8'h00; t_err[2] = 1'b0; t_r0[2] = 8'h1F; t_r1[2] = 8'h00;
        t_code[3] = 8'h01; t_err[3] = 1'b1; t_r0[3] = 8'h1E; t_r1[3] = 8'h01;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b1;
            bus.cmd_code  = t_code[i];
            bus.dht_error = t_err[i];
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            bad = 0;
            for (int j = 0; j < 50; j++) begin
                if (bus.dht_start !== (j < HOLD)) bad++;
                if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) bad++;
                @(negedge clk);
            end
            checks++;
            if (bad !== 0) begin failures++; $display("FAIL read%0d start_window: got %0d bad cycles want 0", i, bad); end
            bus.dht_done = 1'b1;
            @(negedge clk);
            bus.dht_done = 1'b0;
            checks++;
            if (bus.tx_valid !== 1'b1 || bus.tx_byte !== t_r0[i]) begin
                failures++;
                $display("FAIL read%0d byte0: got valid=%b byte=%h want valid=1 byte=%h", i, bus.tx_valid, bus.tx_byte, t_r0[i]);
            end
            @(negedge clk);
            checks++;
            if (bus.tx_valid !== 1'b1 || bus.tx_byte !== t_r1[i]) begin
                failures++;
                $display("FAIL read%0d byte1: got valid=%b byte=%h want valid=1 byte=%h", i, bus.tx_valid, bus.tx_byte, t_r1[i]);
            end
            @(negedge clk);
            checks++;
            if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.tx_valid !== 1'b0 || bus.tx_byte !== 8'h00) begin
                failures++;
                $display("FAIL read%0d idle: got ready=%b busy=%b valid=%b byte=%h want 1 0 0 00",
                         i, bus.cmd_ready, bus.busy, bus.tx_valid, bus.tx_byte);
            end
        end
        bus.dht_error = 1'b0;
    endtask

    task automatic test_timeout;
        int cnt;
        int bad;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_code  = 8'h02;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        cnt = 0;
        while (bus.tx_valid !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (cnt !== TO) begin failures++; $display("FAIL timeout latency: got %0d cycles want %0d", cnt, TO); end
        checks++;
        if (bus.tx_byte !== 8'h1D) begin failures++; $display("FAIL timeout byte0: got %h want 1d", bus.tx_byte); end
        @(negedge clk);
        checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_byte !== 8'h02) begin
            failures++;
            $display("FAIL timeout byte1: got valid=%b byte=%h want valid=1 byte=02", bus.tx_valid, bus.tx_byte);
        end
        @(negedge clk);
        bus.dht_done = 1'b1;
        @(negedge clk);
        bus.dht_done = 1'b0;
        bad = 0;
        for (int j = 0; j < 6; j++) begin
            if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL stale_done_idle: got %0d active cycles want 0", bad); end

        // Done arriving in the very cycle the timeout would fire must win.
        bus.cmd_valid = 1'b1;
        bus.cmd_code  = 8'h01;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int j = 0; j < TO - 1; j++) @(negedge clk);
        bus.dht_done = 1'b1;
        @(negedge clk);
        bus.dht_done = 1'b0;
        checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_byte !== 8'h3F) begin
            failures++;
            $display("FAIL done_vs_timeout byte0: got valid=%b byte=%h want valid=1 byte=3f", bus.tx_valid, bus.tx_byte);
        end
        @(negedge clk);
        checks++;
        if (bus.tx_byte !== 8'h3C) begin failures++; $display("FAIL done_vs_timeout byte1: got %h want 3c", bus.tx_byte); end
        @(negedge clk);
    endtask

    task automatic test_invalid_backpressure;
        int bad;
        bus.tx_ready  = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_code  = 8'h07;
        @(negedge clk);
        bus.cmd_code  = 8'h01;
        checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_byte !== 8'hFF || bus.dht_start !== 1'b0) begin
            failures++;
            $display("FAIL invalid byte0: got valid=%b byte=%h start=%b want 1 ff 0", bus.tx_valid, bus.tx_byte, bus.dht_start);
        end
        bad = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (bus.tx_valid !== 1'b1 || bus.tx_byte !== 8'hFF || bus.cmd_ready !== 1'b0 || bus.dht_start !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL invalid stall: got %0d bad cycles want 0", bad); end
        bus.cmd_valid = 1'b0;
        bus.tx_ready  = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_byte !== 8'hFF) begin
            failures++;
            $display("FAIL invalid byte1: got valid=%b byte=%h want valid=1 byte=ff", bus.tx_valid, bus.tx_byte);
        end
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.dht_start !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL invalid idle: got ready=%b start=%b busy=%b want 1 0 0", bus.cmd_ready, bus.dht_start, bus.busy);
        end
    endtask

    task automatic test_reset_in_wait;
        int bad;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_code  = 8'h01;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int j = 0; j < 10; j++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.dht_start !== 1'b0 || bus.tx_valid !== 1'b0 ||
            bus.tx_byte !== 8'h00 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL wait_reset outputs: got ready=%b start=%b valid=%b byte=%h busy=%b want 1 0 0 00 0",
                     bus.cmd_ready, bus.dht_start, bus.tx_valid, bus.tx_byte, bus.busy);
        end
        bus.dht_done = 1'b1;
        @(negedge clk);
        bus.dht_done = 1'b0;
        bad = 0;
        for (int j = 0; j < 5; j++) begin
            if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL wait_reset no_response: got %0d active cycles want 0", bad); end

        bus.cmd_valid = 1'b1;
        bus.cmd_code  = 8'h01;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int j = 0; j < 10; j++) @(negedge clk);
        bus.dht_done = 1'b1;
        @(negedge clk);
        bus.dht_done = 1'b0;
        checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_byte !== 8'h3F) begin
            failures++;
            $display("FAIL after_reset byte0: got valid=%b byte=%h want valid=1 byte=3f", bus.tx_valid, bus.tx_byte);
        end
        @(negedge clk);
        checks++;
        if (bus.tx_byte !== 8'h3C) begin failures++; $display("FAIL after_reset byte1: got %h want 3c", bus.tx_byte); end
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL after_reset idle: got ready=%b want 1", bus.cmd_ready); end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_code  = 8'h00;
        bus.dht_data  = 40'h3C_00_19_00_55;
        bus.dht_error = 1'b0;
        bus.dht_done  = 1'b0;
        bus.tx_ready  = 1'b1;

        test_reset();
        test_reads();
        test_timeout();
        test_invalid_backpressure();
        test_reset_in_wait();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
